// File: rtl/gated_counter_bank.sv
// Bank of independent up-counters with a global hold gate, per-channel clear/load/enable,
// wrap or saturate mode, terminal-count pulses and a sticky clear/load collision flag.
// Optional snapshot register compiled in with macro GATED_CNT_SNAPSHOT_EN.
module gated_counter_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS-1:0]          clr,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*WIDTH-1:0]    load_val,
  output logic [CHANNELS*WIDTH-1:0]    count,
  output logic [CHANNELS-1:0]          tc,
  output logic                         any_tc,
  output logic                         err
`ifdef GATED_CNT_SNAPSHOT_EN
  ,
  input  logic                         snap,
  output logic [CHANNELS*WIDTH-1:0]    snap_count
`endif
);

  localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   MAX_W  = {1'b0, MAX_V};

  if (STEP < 1 || STEP > (2 ** WIDTH) - 1) begin : g_step_check
    $fatal(1, "gated_counter_bank: STEP out of range 1..2**WIDTH-1");
  end

  logic [CHANNELS*WIDTH-1:0] count_r;
  logic [CHANNELS-1:0]       tc_r;
  logic                      err_r;

  logic [CHANNELS*WIDTH-1:0] count_nxt_s;
  logic [CHANNELS-1:0]       tc_nxt_s;
  logic                      err_nxt_s;
  logic [WIDTH-1:0]          cur_s;
  logic [WIDTH:0]            sum_s;
  logic [WIDTH-1:0]          inc_s;
  logic                      inc_tc_s;

  // Next-state per channel with clr > load > en priority.
  always_comb begin
    count_nxt_s = count_r;
    tc_nxt_s    = {CHANNELS{1'b0}};
    err_nxt_s   = err_r;
    cur_s       = {WIDTH{1'b0}};
    sum_s       = {(WIDTH + 1){1'b0}};
    inc_s       = {WIDTH{1'b0}};
    inc_tc_s    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cur_s = count_r[i*WIDTH +: WIDTH];
      sum_s = {1'b0, cur_s} + STEP_W;
      if (SATURATE != 0) begin
        if (sum_s >= MAX_W) begin
          inc_s = MAX_V;
        end else begin
          inc_s = sum_s[WIDTH-1:0];
        end
        // Pulse only on the step that reaches MAX, not while parked there.
        inc_tc_s = (cur_s != MAX_V) && (inc_s == MAX_V);
      end else begin
        inc_s    = sum_s[WIDTH-1:0];
        inc_tc_s = sum_s[WIDTH];
      end
      if (clr[i]) begin
        count_nxt_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        err_nxt_s                     = err_nxt_s | load[i];
      end else if (load[i]) begin
        count_nxt_s[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
      end else if (en[i]) begin
        count_nxt_s[i*WIDTH +: WIDTH] = inc_s;
        tc_nxt_s[i]                   = inc_tc_s;
      end else begin
        count_nxt_s[i*WIDTH +: WIDTH] = cur_s;
      end
    end
  end

  // Bank state: hold freezes everything except tc, which drops to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {(CHANNELS*WIDTH){1'b0}};
      tc_r    <= {CHANNELS{1'b0}};
      err_r   <= 1'b0;
    end else if (hold) begin
      tc_r    <= {CHANNELS{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

`ifdef GATED_CNT_SNAPSHOT_EN
  logic [CHANNELS*WIDTH-1:0] snap_r;

  // Snapshot captures the pre-update counts of all channels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_r <= {(CHANNELS*WIDTH){1'b0}};
    end else if (!hold && snap) begin
      snap_r <= count_r;
    end else begin
      snap_r <= snap_r;
    end
  end

  assign snap_count = snap_r;
`endif

  assign count  = count_r;
  assign tc     = tc_r;
  assign any_tc = |tc_r;
  assign err    = err_r;

endmodule

// File: tb/tb_gated_counter_bank.sv
// Directed self-checking bench: a wrap-mode bank (STEP=1) and a saturate-mode bank (STEP=3).
module tb_gated_counter_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic [3:0]  en, clr, load;
  logic [31:0] load_val;
  logic [31:0] count;
  logic [3:0]  tc;
  logic        any_tc, err;
  logic [3:0]  s_en, s_clr, s_load;
  logic [31:0] s_load_val;
  logic [31:0] s_count;
  logic [3:0]  s_tc;
  logic        s_any_tc, s_err;
`ifdef GATED_CNT_SNAPSHOT_EN
  logic        snap, s_snap;
  logic [31:0] snap_count, s_snap_count;
`endif

  int errors = 0;
  int checks = 0;

  gated_counter_bank #(.CHANNELS(4), .WIDTH(8), .STEP(1), .SATURATE(0)) dut (
    .clock(clock), .reset(reset), .hold(hold), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .any_tc(any_tc), .err(err)
`ifdef GATED_CNT_SNAPSHOT_EN
    , .snap(snap), .snap_count(snap_count)
`endif
  );

  gated_counter_bank #(.CHANNELS(4), .WIDTH(8), .STEP(3), .SATURATE(1)) dut_s (
    .clock(clock), .reset(reset), .hold(hold), .en(s_en), .clr(s_clr), .load(s_load),
    .load_val(s_load_val), .count(s_count), .tc(s_tc), .any_tc(s_any_tc), .err(s_err)
`ifdef GATED_CNT_SNAPSHOT_EN
    , .snap(s_snap), .snap_count(s_snap_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ch(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic clear_ctl;
    hold = 1'b0; en = 4'h0; clr = 4'h0; load = 4'h0;
    s_en = 4'h0; s_clr = 4'h0; s_load = 4'h0;
`ifdef GATED_CNT_SNAPSHOT_EN
    snap = 1'b0; s_snap = 1'b0;
`endif
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++; if (count !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", count); end
    checks++; if (tc !== 4'h0 || any_tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b/%b exp=0", tc, any_tc); end
    checks++; if (err !== 1'b0 || s_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b/%b exp=0", err, s_err); end
    checks++; if (s_count !== 32'h0) begin errors++; $display("FAIL reset_s_count got=%h exp=0", s_count); end
    reset = 1'b0;
    tick();
    checks++; if (count !== 32'h0) begin errors++; $display("FAIL idle_count got=%h exp=0", count); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_c [3] = '{8'hFF, 8'h00, 8'h01};
    logic       exp_t [3] = '{1'b0, 1'b1, 1'b0};
    load[1] = 1'b1; load_val[15:8] = 8'hFE;
    tick(); clear_ctl();
    checks++; if (ch(count, 1) !== 8'hFE || tc !== 4'h0) begin errors++; $display("FAIL wrap_load got=%h tc=%b exp=fe tc=0", ch(count, 1), tc); end
    for (int k = 0; k < 3; k++) begin
      en[1] = 1'b1;
      tick();
      checks++; if (ch(count, 1) !== exp_c[k]) begin errors++; $display("FAIL wrap_count[%0d] got=%h exp=%h", k, ch(count, 1), exp_c[k]); end
      checks++; if (tc !== {2'b00, exp_t[k], 1'b0} || any_tc !== exp_t[k]) begin errors++; $display("FAIL wrap_tc[%0d] got=%b/%b exp=%b", k, tc, any_tc, exp_t[k]); end
    end
    clear_ctl();
    tick();
    checks++; if (ch(count, 1) !== 8'h01 || tc !== 4'h0) begin errors++; $display("FAIL wrap_idle got=%h tc=%b exp=01 tc=0", ch(count, 1), tc); end
    checks++; if (ch(count, 0) !== 8'h00 || ch(count, 2) !== 8'h00) begin errors++; $display("FAIL wrap_indep got=%h exp=0", count); end
  endtask

  task automatic test_saturate;
    logic [7:0] exp_c [3] = '{8'hFD, 8'hFF, 8'hFF};
    logic       exp_t [3] = '{1'b0, 1'b1, 1'b0};
    s_load[0] = 1'b1; s_load_val[7:0] = 8'hFA; s_en[3] = 1'b1;
    tick(); clear_ctl();
    checks++; if (ch(s_count, 0) !== 8'hFA || ch(s_count, 3) !== 8'h03 || s_tc !== 4'h0) begin errors++; $display("FAIL sat_load got=%h tc=%b exp=030000fa tc=0", s_count, s_tc); end
    for (int k = 0; k < 3; k++) begin
      s_en[0] = 1'b1;
      tick();
      checks++; if (ch(s_count, 0) !== exp_c[k]) begin errors++; $display("FAIL sat_count[%0d] got=%h exp=%h", k, ch(s_count, 0), exp_c[k]); end
      checks++; if (s_tc !== {3'b000, exp_t[k]} || s_any_tc !== exp_t[k]) begin errors++; $display("FAIL sat_tc[%0d] got=%b exp=%b", k, s_tc, exp_t[k]); end
    end
    clear_ctl();
    s_load[1] = 1'b1; s_load_val[15:8] = 8'hFF;
    tick(); clear_ctl();
    checks++; if (ch(s_count, 1) !== 8'hFF || s_tc !== 4'h0) begin errors++; $display("FAIL sat_load_max got=%h tc=%b exp=ff tc=0", ch(s_count, 1), s_tc); end
  endtask

  task automatic test_hold;
    load = 4'b0011; load_val[15:0] = 16'hFF05;
    tick(); clear_ctl();
    en = 4'b0010;
    tick(); clear_ctl();
    checks++; if (ch(count, 1) !== 8'h00 || tc !== 4'b0010) begin errors++; $display("FAIL hold_pre got=%h tc=%b exp=00 tc=0010", ch(count, 1), tc); end
    for (int k = 0; k < 4; k++) begin
      hold = 1'b1; en = 4'b0011; clr[3] = 1'b1; load[3] = 1'b1; load_val[31:24] = 8'h44;
      tick();
      checks++; if (ch(count, 0) !== 8'h05 || ch(count, 1) !== 8'h00 || ch(count, 3) !== 8'h00) begin errors++; $display("FAIL hold_count[%0d] got=%h exp=00000005", k, count); end
      checks++; if (tc !== 4'h0 || err !== 1'b0) begin errors++; $display("FAIL hold_tc_err[%0d] got=%b/%b exp=0/0", k, tc, err); end
    end
    clear_ctl();
    en[0] = 1'b1;
    tick(); clear_ctl();
    checks++; if (ch(count, 0) !== 8'h06 || tc !== 4'h0) begin errors++; $display("FAIL hold_release got=%h tc=%b exp=06 tc=0", ch(count, 0), tc); end
  endtask

  task automatic test_error;
    load[2] = 1'b1; load_val[23:16] = 8'h10;
    tick(); clear_ctl();
    checks++; if (ch(count, 2) !== 8'h10 || err !== 1'b0) begin errors++; $display("FAIL err_pre got=%h err=%b exp=10 err=0", ch(count, 2), err); end
    clr[2] = 1'b1; load[2] = 1'b1; load_val[23:16] = 8'h22; en[0] = 1'b1;
    tick(); clear_ctl();
    checks++; if (ch(count, 2) !== 8'h00 || err !== 1'b1) begin errors++; $display("FAIL err_set got=%h err=%b exp=00 err=1", ch(count, 2), err); end
    checks++; if (ch(count, 0) !== 8'h07) begin errors++; $display("FAIL err_indep got=%h exp=07", ch(count, 0)); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    clr[2] = 1'b1;
    tick(); clear_ctl();
    checks++; if (err !== 1'b1 || ch(count, 2) !== 8'h00) begin errors++; $display("FAIL err_after_clr got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid;
    load = 4'b0011; load_val[15:0] = 16'hFF37;
    tick(); clear_ctl();
    checks++; if (ch(count, 0) !== 8'h37) begin errors++; $display("FAIL mid_load got=%h exp=37", ch(count, 0)); end
    en[1] = 1'b1;
    tick(); clear_ctl();
    checks++; if (tc !== 4'b0010 || err !== 1'b1) begin errors++; $display("FAIL mid_pre got tc=%b err=%b exp=0010/1", tc, err); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 32'h0 || tc !== 4'h0 || any_tc !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_async got=%h tc=%b err=%b exp=0", count, tc, err); end
    @(negedge clock);
    reset = 1'b0; en[0] = 1'b1;
    tick(); clear_ctl();
    checks++; if (ch(count, 0) !== 8'h01 || err !== 1'b0) begin errors++; $display("FAIL mid_resume got=%h err=%b exp=01/0", ch(count, 0), err); end
  endtask

`ifdef GATED_CNT_SNAPSHOT_EN
  task automatic test_snapshot;
    load[0] = 1'b1; load_val[7:0] = 8'h09;
    tick(); clear_ctl();
    en[0] = 1'b1; snap = 1'b1;
    tick(); clear_ctl();
    checks++; if (ch(snap_count, 0) !== 8'h09 || ch(count, 0) !== 8'h0A) begin errors++; $display("FAIL snap_take got=%h cnt=%h exp=09/0a", ch(snap_count, 0), ch(count, 0)); end
    en[0] = 1'b1; hold = 1'b1; snap = 1'b1;
    tick(); clear_ctl();
    en[0] = 1'b1;
    tick(); clear_ctl();
    checks++; if (ch(snap_count, 0) !== 8'h09 || ch(count, 0) !== 8'h0B) begin errors++; $display("FAIL snap_keep got=%h cnt=%h exp=09/0b", ch(snap_count, 0), ch(count, 0)); end
  endtask
`endif

  initial begin
    reset = 1'b1; load_val = 32'h0; s_load_val = 32'h0;
    clear_ctl();
    test_reset();
    test_wrap();
    test_saturate();
    test_hold();
    test_error();
    test_reset_mid();
`ifdef GATED_CNT_SNAPSHOT_EN
    test_snapshot();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
